// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter: default tap count, tap-select width,
// MAC pipeline latency, and the sequencer state encoding. The delay line, MAC
// and sequencer all take their defaults from here so a single edit keeps the
// three blocks consistent.
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int N_TAPS      = 16;  // filter taps, at least 2
   localparam int LOG2_N_TAPS = 4;   // tap select width, 2**LOG2_N_TAPS >= N_TAPS
   localparam int MAC_LAT     = 1;   // last mac_en to stable MAC output, 0..7
   localparam int LAT_W       = 3;   // width able to hold MAC_LAT-1 for MAC_LAT <= 7

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      MAC   = 3'd2,
      DRAIN = 3'd3,
      OUT   = 3'd4
   } fir_seq_state_t;

endpackage

// File: rtl/tap_counter.sv
// -----------------------------------------------------------------------------
// tap_counter
// Loadable up-counter that walks the tap/coefficient select 0..N_TAPS-1.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset, clears the count
//   load_i   reload the count with 0 (has priority over en_i)
//   en_i     advance the count by one; wraps to 0 after N_TAPS-1
//   count_o  current tap index
//   last_o   high while count_o == N_TAPS-1
// -----------------------------------------------------------------------------
module tap_counter #(
   parameter int N_TAPS = fir_pkg::N_TAPS,
   parameter int WIDTH  = fir_pkg::LOG2_N_TAPS
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic             last_o
);

   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(N_TAPS - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (en_i) begin
         // Wrap explicitly so non-power-of-two tap counts stay in range.
         count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
// Control FSM for the FIR datapath. Accepts one sample per in_valid/in_ready
// handshake, shifts the delay line once, clears the MAC and then accumulates
// every tap in order, waits out the MAC pipeline, and offers the result with
// an out_valid/out_ready handshake. All outputs decode from registers only.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   sample present at the delay-line input
//   in_ready_o   sequencer can accept a sample (IDLE)
//   shift_en_o   delay-line enable, one pulse per accepted sample
//   tap_sel_o    tap/coefficient select, non-zero only while accumulating
//   mac_clr_o    synchronous clear of the MAC accumulator
//   mac_en_o     accumulate the product for tap_sel_o
//   out_valid_o  MAC result valid
//   out_ready_i  downstream accepts the result
//   primed_o     at least N_TAPS samples shifted in since reset
// -----------------------------------------------------------------------------
module fir_sequencer #(
   parameter int N_TAPS      = fir_pkg::N_TAPS,
   parameter int LOG2_N_TAPS = fir_pkg::LOG2_N_TAPS,
   parameter int MAC_LAT     = fir_pkg::MAC_LAT
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic                   shift_en_o,
   output logic [LOG2_N_TAPS-1:0] tap_sel_o,
   output logic                   mac_clr_o,
   output logic                   mac_en_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   primed_o
);

   import fir_pkg::*;

   if (N_TAPS < 2 || (2 ** LOG2_N_TAPS) < N_TAPS || MAC_LAT < 0 || MAC_LAT > 7) begin : g_bad_params
      $error("fir_sequencer: illegal parameter combination");
   end

   // DRAIN is entered with MAC_LAT-1 and left when the counter reads 0,
   // giving exactly MAC_LAT drain cycles.
   localparam logic [LAT_W-1:0] LAT_INIT =
      (MAC_LAT > 0) ? LAT_W'(MAC_LAT - 1) : '0;
   localparam logic [LOG2_N_TAPS:0] PRIMED_CNT = (LOG2_N_TAPS + 1)'(N_TAPS);

   fir_seq_state_t         state_q, state_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [LOG2_N_TAPS:0]   shift_cnt_q, shift_cnt_d;

   logic [LOG2_N_TAPS-1:0] tap_cnt;
   logic                   tap_last;
   logic                   accept;

   tap_counter #(
      .N_TAPS (N_TAPS),
      .WIDTH  (LOG2_N_TAPS)
   ) u_tap_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (state_q == SHIFT),
      .en_i    (state_q == MAC),
      .count_o (tap_cnt),
      .last_o  (tap_last)
   );

   assign accept = (state_q == IDLE) && in_valid_i;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            state_d = MAC;
         end
         MAC: begin
            if (tap_last) begin
               if (MAC_LAT == 0) begin
                  state_d = OUT;
               end else begin
                  state_d = DRAIN;
                  lat_d   = LAT_INIT;
               end
            end
         end
         DRAIN: begin
            if (lat_q == '0) begin
               state_d = OUT;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         OUT: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The accept edge is the edge that starts SHIFT, so counting accepts makes
   // primed_o visible in the SHIFT cycle of the N_TAPS-th sample.
   always_comb begin
      shift_cnt_d = shift_cnt_q;
      if (accept && (shift_cnt_q != PRIMED_CNT)) begin
         shift_cnt_d = shift_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         shift_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         shift_cnt_q <= shift_cnt_d;
      end
   end

   // Output decode, from registered state only.
   always_comb begin
      in_ready_o  = 1'b0;
      shift_en_o  = 1'b0;
      mac_clr_o   = 1'b0;
      mac_en_o    = 1'b0;
      out_valid_o = 1'b0;
      tap_sel_o   = '0;
      unique case (state_q)
         IDLE:  in_ready_o = 1'b1;
         SHIFT: begin
            shift_en_o = 1'b1;
            mac_clr_o  = 1'b1;
         end
         MAC: begin
            mac_en_o  = 1'b1;
            tap_sel_o = tap_cnt;
         end
         OUT:   out_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign primed_o = (shift_cnt_q == PRIMED_CNT);

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
// Three sequencers (MAC_LAT = 1, 0, 3) share one stimulus stream. A reference
// model tracks, per instance, whether a sample is in flight and how many
// cycles have passed since its accept edge; expected outputs follow directly
// from the cycle-offset timing rules.
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

   localparam int N  = 16;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic in_valid;
   logic out_ready;

   logic [NI-1:0]      in_ready, shift_en, mac_clr, mac_en, out_valid, primed;
   logic [NI-1:0][3:0] tap_sel;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      fir_sequencer #(
         .N_TAPS      (16),
         .LOG2_N_TAPS (4),
         .MAC_LAT     ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .in_valid_i  (in_valid),
         .in_ready_o  (in_ready[gi]),
         .shift_en_o  (shift_en[gi]),
         .tap_sel_o   (tap_sel[gi]),
         .mac_clr_o   (mac_clr[gi]),
         .mac_en_o    (mac_en[gi]),
         .out_valid_o (out_valid[gi]),
         .out_ready_i (out_ready),
         .primed_o    (primed[gi])
      );
   end

   // ---------------- reference model ----------------
   bit busy   [NI];
   int k      [NI];   // cycles since the accept edge
   int shifts [NI];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   function automatic int lat_of(int i);
      if (i == 0) return 1;
      if (i == 1) return 0;
      return 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         busy[i]   = 1'b0;
         k[i]      = 0;
         shifts[i] = 0;
      end
   endtask

   // One clock: advance the model on the rising edge, return on the falling edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            busy[i]   = 1'b0;
            shifts[i] = 0;
         end else if (!busy[i]) begin
            if (in_valid) begin
               busy[i] = 1'b1;
               k[i]    = 1;
               shifts[i]++;
            end
         end else if (k[i] >= N + lat_of(i) + 2) begin
            if (out_ready) busy[i] = 1'b0;
         end else begin
            k[i]++;
         end
      end
      @(negedge clk);
   endtask

   // {in_ready, shift_en, mac_clr, mac_en, out_valid, primed, tap_sel[3:0]}
   function automatic logic [9:0] expv(int i);
      logic       ir, se, mc, me, ov;
      logic [3:0] ts;
      int         l;
      ir = 1'b0; se = 1'b0; mc = 1'b0; me = 1'b0; ov = 1'b0; ts = 4'd0;
      l  = lat_of(i);
      if (!busy[i]) begin
         ir = 1'b1;
      end else if (k[i] == 1) begin
         se = 1'b1;
         mc = 1'b1;
      end else if (k[i] <= N + 1) begin
         me = 1'b1;
         ts = 4'(k[i] - 2);
      end else if (k[i] >= N + l + 2) begin
         ov = 1'b1;
      end
      return {ir, se, mc, me, ov, (shifts[i] >= N), ts};
   endfunction

   function automatic logic [9:0] obs(int i);
      return {in_ready[i], shift_en[i], mac_clr[i], mac_en[i], out_valid[i],
              primed[i], tap_sel[i]};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      model_reset();
      step();
      step();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs(i) !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_hold dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), 10'b10_0000_0000);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL reset_idle dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
         end
      end
   endtask

   task automatic test_single();
      int t_acc;
      int n_mac   [NI];
      int n_ov    [NI];
      int first_ov[NI];
      for (int i = 0; i < NI; i++) begin
         n_mac[i] = 0; n_ov[i] = 0; first_ov[i] = -1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      t_acc    = cyc - 1;
      in_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL single dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
            if (mac_en[i]) n_mac[i]++;
            if (out_valid[i]) begin
               n_ov[i]++;
               if (first_ov[i] < 0) first_ov[i] = cyc;
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (n_mac[i] !== N) begin
            errors++;
            $display("FAIL single_mac_count dut%0d: got %0d expected %0d", i, n_mac[i], N);
         end
         checks++;
         if (n_ov[i] !== 1 || first_ov[i] !== t_acc + N + lat_of(i) + 2) begin
            errors++;
            $display("FAIL single_out_valid dut%0d: got %0d pulses at cyc %0d expected 1 at cyc %0d",
                     i, n_ov[i], first_ov[i], t_acc + N + lat_of(i) + 2);
         end
      end
   endtask

   task automatic test_back_to_back();
      int last_shift[NI];
      for (int i = 0; i < NI; i++) last_shift[i] = -1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 17 * 20 + 5; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL b2b dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
            if (shift_en[i]) begin
               if (last_shift[i] >= 0) begin
                  checks++;
                  if (cyc - last_shift[i] !== N + lat_of(i) + 3) begin
                     errors++;
                     $display("FAIL b2b_period dut%0d cyc %0d: got %0d expected %0d",
                              i, cyc, cyc - last_shift[i], N + lat_of(i) + 3);
                  end
               end
               last_shift[i] = cyc;
            end
         end
      end
   endtask

   task automatic test_stall();
      int n_shift[NI];
      for (int i = 0; i < NI; i++) n_shift[i] = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL stall_settle dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
         end
      end
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c < 76; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL stall dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
            if (shift_en[i]) n_shift[i]++;
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (n_shift[i] !== 1 || out_valid[i] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold dut%0d: got %0d shifts out_valid %b expected 1 shift out_valid 1",
                     i, n_shift[i], out_valid[i]);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL stall_release dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (tap_sel[0] == 4'd7) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_wait: tap_sel never reached 7 within 40 cycles, got %0d", tap_sel[0]);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs(i) !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_mid_async dut%0d: got %b expected %b", i, obs(i), 10'b10_0000_0000);
         end
      end
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL reset_mid_after dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: got %b expected %b", i, cyc, obs(i), expv(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Control FSM for the FIR filter datapath. Accepts one input sample per handshake and pulses the tap delay line's `enable` once per accepted sample. Steps the coefficient/tap select across all taps while driving the MAC clear/accumulate strobes, waits out the MAC pipeline latency, and then presents a result-valid handshake to the downstream consumer. It sits between the sample source and the `register`-based delay line plus MAC, and owns all of their enables.

## Interface
Parameters:
- `N_TAPS`, 16: number of filter taps; must be at least 2.
- `LOG2_N_TAPS`, 4: width of the tap select; `2**LOG2_N_TAPS >= N_TAPS`.
- `MAC_LAT`, 1: cycles from the last `mac_en` to the MAC output being stable; range 0..7.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a new sample is present at the delay-line input.
- `in_ready` out 1: the sequencer can accept a sample.
- `shift_en` out 1: enable to the delay line; one-cycle pulse per accepted sample.
- `tap_sel` out `LOG2_N_TAPS`: tap/coefficient select for the MAC operand muxes.
- `mac_clr` out 1: synchronous clear of the MAC accumulator.
- `mac_en` out 1: accumulate the product for the current `tap_sel`.
- `out_valid` out 1: the MAC result is valid.
- `out_ready` in 1: the downstream consumer accepts the result.
- `primed` out 1: at least `N_TAPS` samples have been shifted in since reset.

## Operation
- The FSM has five states: IDLE, SHIFT, MAC, DRAIN, OUT. All outputs are decoded from registered state and counters, with no combinational path from inputs to outputs.
- IDLE: `in_ready`=1. If `in_valid` is high at the edge, the handshake completes and the FSM moves to SHIFT. Otherwise it stays in IDLE.
- SHIFT (1 cycle): `shift_en`=1 and `mac_clr`=1. The tap counter is loaded with 0. The FSM moves to MAC.
- MAC (`N_TAPS` cycles): `mac_en`=1 and `tap_sel`=tap counter, which runs 0, 1, …, `N_TAPS-1`. When `tap_sel`=`N_TAPS-1`, the FSM moves to DRAIN, or to OUT if `MAC_LAT`=0.
- DRAIN (`MAC_LAT` cycles): all strobes are 0. The latency counter counts down, and the FSM moves to OUT when it reaches the last cycle.
- OUT: `out_valid`=1 and holds until `out_ready`=1 at an edge, then the FSM returns to IDLE. A stalled `out_ready` holds OUT indefinitely; `tap_sel` and the strobes stay 0.
- `tap_sel`=0 in every state except MAC.
- `in_valid` is ignored outside IDLE. The source must hold the sample and `in_valid` until `in_ready`.
- `primed`: a saturating count of SHIFT cycles sets `primed` on the `N_TAPS`-th shift and keeps it set until reset. Counter width is `LOG2_N_TAPS+1`. It never wraps.
- Reset (any state, any cycle): the FSM goes immediately to IDLE and all counters clear. `shift_en`, `mac_en`, `mac_clr`, `out_valid`, `primed` and `tap_sel` are all 0. `in_ready`=1 while `reset` is low, but no handshake completes while `reset` is low.
- An in-flight computation aborted by reset produces no `out_valid`.

## Timing
- Accept edge t: SHIFT at cycle t+1, MAC at cycles t+2..t+`N_TAPS`+1, DRAIN for the next `MAC_LAT` cycles.
- `out_valid` first rises at cycle t+`N_TAPS`+`MAC_LAT`+2.
- Minimum sample period (with `out_ready` tied high) is `N_TAPS`+`MAC_LAT`+3 cycles; the extra cycle is IDLE.
- `shift_en` and `mac_clr` coincide in the same single cycle. The delay line has shifted before the first `mac_en`.
- The `out_ready` handshake edge leaves `out_valid`=0 and `in_ready`=1 in the following cycle.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum `fir_seq_state_t` (IDLE, SHIFT, MAC, DRAIN, OUT);
  - the default constants `N_TAPS`, `LOG2_N_TAPS` and `MAC_LAT`, shared with the delay line and MAC.
- One sub-module, `tap_counter`, provides the loadable up-counter used for `tap_sel`. It has `load`, `en` and a `last` flag at `N_TAPS-1`.
- The latency down-counter and the `primed` counter stay inline.

## Test plan
- Reset release, `in_valid`=0 for 10 cycles: `in_ready`=1, all strobes 0, `primed`=0, `tap_sel`=0.
- One sample with `N_TAPS`=16, `MAC_LAT`=1, `out_ready`=1. Accept at edge t:
  - `shift_en` pulses at t+1;
  - `mac_en` is high for 16 cycles with `tap_sel` 0..15;
  - `out_valid` is 1 at cycle t+19 only.
- Back-to-back samples with `in_valid` held at 1: accepts are exactly 20 cycles apart, and `primed` rises in the SHIFT cycle of the 16th sample.
- Hold `out_ready`=0 for 50 cycles in OUT: `out_valid` stays 1, `in_ready`=0, `in_valid` is ignored, and there is no extra `shift_en`.
- Assert `reset` low at `tap_sel`=7 in MAC: all outputs 0 immediately. After release, no `out_valid` and `primed`=0.
- `MAC_LAT`=0 build: `out_valid` in the cycle directly after `tap_sel`=`N_TAPS-1`.
